// File: rtl/ysyx_22040125_halt_pkg.sv
// Shared types and defaults for the halt controller.
package ysyx_22040125_halt_pkg;

  // Halt controller FSM states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2,
    HALTED = 2'd3
  } halt_state_e;

  // Default maximum number of DRAIN cycles before a forced report
  localparam int HALT_DRAIN_TIMEOUT_DEF = 16;

endpackage

// File: rtl/ysyx_22040125_halt_timer.sv
// Clearable saturating up-counter with a terminal-count flag.
// The count stops at LIMIT-1; tc is high while the count sits there.
module ysyx_22040125_halt_timer #(
  parameter int LIMIT = 16,
  parameter int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(LIMIT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] count_r;
  logic          tc_s;

  assign tc_s = (count_r == TC_VAL);
  assign tc   = tc_s;

  // Count register: clear wins over enable, never wraps past TC_VAL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && !tc_s) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ysyx_22040125_halt_ctrl.sv
// Halt controller: freezes the core on an ebreak pulse, waits for the
// pipeline to drain (bounded), reports trap PC / exit code over a
// valid/ready handshake and keeps the core halted until resumed.
module ysyx_22040125_halt_ctrl
  import ysyx_22040125_halt_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int DRAIN_TIMEOUT = HALT_DRAIN_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_in,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_code,
  input  logic            pipe_idle,
  output logic            stall_req,
  output logic            rpt_valid,
  input  logic            rpt_ready,
  output logic [XLEN-1:0] rpt_pc,
  output logic [XLEN-1:0] rpt_code,
  output logic            rpt_good,
  output logic            rpt_timeout,
  output logic            halted,
  input  logic            resume
);

  halt_state_e     state_r;
  halt_state_e     state_next_s;
  logic            capture_s;
  logic            timer_clr_s;
  logic            timer_tc_s;
  logic            timeout_next_s;
  logic            timeout_r;
  logic            stall_req_r;
  logic            rpt_valid_r;
  logic            halted_r;
  logic [XLEN-1:0] rpt_pc_r;
  logic [XLEN-1:0] rpt_code_r;

  // Drain bound: counts only while in DRAIN, cleared on trap capture / resume
  ysyx_22040125_halt_timer #(
    .LIMIT (DRAIN_TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr_s),
    .en  (state_r == DRAIN),
    .tc  (timer_tc_s)
  );

  // Next-state logic and capture/clear strobes
  always_comb begin
    state_next_s   = state_r;
    capture_s      = 1'b0;
    timer_clr_s    = 1'b0;
    timeout_next_s = timeout_r;
    case (state_r)
      RUN: begin
        if (trap_in) begin
          state_next_s = DRAIN;
          capture_s    = 1'b1;
          timer_clr_s  = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        // An idle pipeline beats the timeout when both hold together
        if (pipe_idle) begin
          state_next_s   = REPORT;
          timeout_next_s = 1'b0;
        end else if (timer_tc_s) begin
          state_next_s   = REPORT;
          timeout_next_s = 1'b1;
        end else begin
          state_next_s = DRAIN;
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = REPORT;
        end
      end
      HALTED: begin
        // resume wins over a simultaneous trap; the trap is dropped
        if (resume) begin
          state_next_s   = RUN;
          timeout_next_s = 1'b0;
          timer_clr_s    = 1'b1;
        end else begin
          state_next_s = HALTED;
        end
      end
      default: begin
        state_next_s   = RUN;
        timeout_next_s = 1'b0;
        timer_clr_s    = 1'b1;
      end
    endcase
  end

  // State, registered status outputs and trap capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      stall_req_r <= 1'b0;
      rpt_valid_r <= 1'b0;
      halted_r    <= 1'b0;
      timeout_r   <= 1'b0;
      rpt_pc_r    <= '0;
      rpt_code_r  <= '0;
    end else begin
      state_r     <= state_next_s;
      stall_req_r <= (state_next_s != RUN);
      rpt_valid_r <= (state_next_s == REPORT);
      halted_r    <= (state_next_s == HALTED);
      timeout_r   <= timeout_next_s;
      if (capture_s) begin
        rpt_pc_r   <= trap_pc;
        rpt_code_r <= trap_code;
      end else begin
        rpt_pc_r   <= rpt_pc_r;
        rpt_code_r <= rpt_code_r;
      end
    end
  end

  assign stall_req   = stall_req_r;
  assign rpt_valid   = rpt_valid_r;
  assign halted      = halted_r;
  assign rpt_timeout = timeout_r;
  assign rpt_pc      = rpt_pc_r;
  assign rpt_code    = rpt_code_r;
  assign rpt_good    = ~(|rpt_code_r);

endmodule

// File: tb/tb_ysyx_22040125_halt_ctrl.sv
// Self-checking bench for ysyx_22040125_halt_ctrl: expected reports are
// queued when a trap is driven and popped when rpt_valid appears.
module tb_ysyx_22040125_halt_ctrl;

  localparam int XLEN = 64;
  localparam int DT   = 16;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] code;
    logic            good;
    logic            tmo;
    int              lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            trap_in = 1'b0;
  logic [XLEN-1:0] trap_pc = '0;
  logic [XLEN-1:0] trap_code = '0;
  logic            pipe_idle = 1'b0;
  logic            stall_req;
  logic            rpt_valid;
  logic            rpt_ready = 1'b0;
  logic [XLEN-1:0] rpt_pc;
  logic [XLEN-1:0] rpt_code;
  logic            rpt_good;
  logic            rpt_timeout;
  logic            halted;
  logic            resume = 1'b0;

  exp_t sb_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  ysyx_22040125_halt_ctrl #(
    .XLEN          (XLEN),
    .DRAIN_TIMEOUT (DT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trap_in     (trap_in),
    .trap_pc     (trap_pc),
    .trap_code   (trap_code),
    .pipe_idle   (pipe_idle),
    .stall_req   (stall_req),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_pc      (rpt_pc),
    .rpt_code    (rpt_code),
    .rpt_good    (rpt_good),
    .rpt_timeout (rpt_timeout),
    .halted      (halted),
    .resume      (resume)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock, land 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stall"},   64'(stall_req),   64'd0);
    chk({tag, "_valid"},   64'(rpt_valid),   64'd0);
    chk({tag, "_pc"},      rpt_pc,           64'd0);
    chk({tag, "_code"},    rpt_code,         64'd0);
    chk({tag, "_good"},    64'(rpt_good),    64'd1);
    chk({tag, "_timeout"}, 64'(rpt_timeout), 64'd0);
    chk({tag, "_halted"},  64'(halted),      64'd0);
  endtask

  // drive a one-cycle trap from RUN and queue its expected report
  task automatic do_trap(input logic [63:0] pc, input logic [63:0] code,
                         input logic tmo, input int lat);
    exp_t e;
    e.pc   = pc;
    e.code = code;
    e.good = (code == 64'd0);
    e.tmo  = tmo;
    e.lat  = lat;
    sb_q.push_back(e);
    trap_pc   = pc;
    trap_code = code;
    trap_in   = 1'b1;
    step();
    trap_in = 1'b0;
    chk("trap_stall", 64'(stall_req), 64'd1);
  endtask

  // wait for rpt_valid (k0 edges already elapsed since the trap edge)
  task automatic wait_report(input string tag, input int k0);
    exp_t e;
    int   k;
    bit   seen;
    k    = k0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!seen) begin
        step();
        k++;
        if (rpt_valid) seen = 1'b1;
      end
    end
    if (!seen) begin
      chk({tag, "_no_report"}, 64'd0, 64'd1);
    end else if (sb_q.size() == 0) begin
      chk({tag, "_unexpected"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_latency"}, 64'(k + 1),      64'(e.lat));
      chk({tag, "_pc"},      rpt_pc,          e.pc);
      chk({tag, "_code"},    rpt_code,        e.code);
      chk({tag, "_good"},    64'(rpt_good),   64'(e.good));
      chk({tag, "_timeout"}, 64'(rpt_timeout),64'(e.tmo));
      chk({tag, "_halted"},  64'(halted),     64'd0);
    end
  endtask

  task automatic do_resume(input string tag);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk({tag, "_stall"},  64'(stall_req), 64'd0);
    chk({tag, "_halted"}, 64'(halted),    64'd0);
  endtask

  initial begin
    // reset state
    #2;
    chk_reset_vals("rst");
    step();
    step();
    rst = 1'b1;
    step();
    chk_reset_vals("post_rst");

    // good trap, ready already high
    pipe_idle = 1'b1;
    rpt_ready = 1'b1;
    do_trap(64'h8000_0010, 64'd0, 1'b0, 2);
    wait_report("good", 0);
    step();
    chk("good_halted", 64'(halted),    64'd1);
    chk("good_vdrop",  64'(rpt_valid), 64'd0);
    do_resume("res1");

    // bad trap with 5 cycles of backpressure, resume ignored in REPORT
    rpt_ready = 1'b0;
    do_trap(64'h8000_0020, 64'd1, 1'b0, 2);
    wait_report("bad", 0);
    for (int i = 0; i < 5; i++) begin
      resume = (i == 2);
      step();
      chk("bp_valid",  64'(rpt_valid), 64'd1);
      chk("bp_pc",     rpt_pc,         64'h8000_0020);
      chk("bp_code",   rpt_code,       64'd1);
      chk("bp_good",   64'(rpt_good),  64'd0);
      chk("bp_halted", 64'(halted),    64'd0);
    end
    resume    = 1'b0;
    rpt_ready = 1'b1;
    step();
    chk("bp_halted_after", 64'(halted),    64'd1);
    chk("bp_vdrop",        64'(rpt_valid), 64'd0);
    rpt_ready = 1'b0;
    do_resume("res2");

    // timeout path with an ignored second trap during DRAIN
    pipe_idle = 1'b0;
    rpt_ready = 1'b1;
    do_trap(64'h8000_0030, 64'h5, 1'b1, DT + 1);
    trap_pc   = 64'hDEAD;
    trap_code = 64'h77;
    trap_in   = 1'b1;
    step();
    trap_in = 1'b0;
    chk("drain_novalid", 64'(rpt_valid), 64'd0);
    wait_report("tmo", 1);
    step();
    chk("tmo_halted", 64'(halted), 64'd1);
    do_resume("res3");
    chk("res3_tmo_clr", 64'(rpt_timeout), 64'd0);

    // retrap after resume reports the new code with timeout cleared
    pipe_idle = 1'b1;
    do_trap(64'h8000_0040, 64'h2, 1'b0, 2);
    wait_report("retrap", 0);
    step();
    chk("retrap_halted", 64'(halted), 64'd1);

    // trap and resume together while HALTED: resume wins, trap dropped
    trap_pc   = 64'hBAD;
    trap_code = 64'h9;
    trap_in   = 1'b1;
    resume    = 1'b1;
    step();
    trap_in = 1'b0;
    resume  = 1'b0;
    chk("tr_stall",  64'(stall_req), 64'd0);
    chk("tr_halted", 64'(halted),    64'd0);
    chk("tr_pc",     rpt_pc,         64'h8000_0040);
    step();
    chk("tr_stall2", 64'(stall_req), 64'd0);

    // async reset mid-DRAIN
    pipe_idle = 1'b0;
    do_trap(64'h8000_0050, 64'h3, 1'b0, 2);
    step();
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_drain");
    sb_q.delete();
    step();
    rst = 1'b1;
    step();
    chk("rst_drain_run", 64'(stall_req), 64'd0);

    // async reset mid-REPORT drops the pending report
    pipe_idle = 1'b1;
    rpt_ready = 1'b0;
    do_trap(64'h8000_0060, 64'h4, 1'b0, 2);
    wait_report("prerst", 0);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_report");
    step();
    rst = 1'b1;
    step();
    chk("rst_report_run",   64'(stall_req), 64'd0);
    chk("rst_report_valid", 64'(rpt_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040125_halt_ctrl.md
# ysyx_22040125_halt_ctrl

Consumer end of the trap-signal path. It takes the registered ebreak pulse from the core's trap delay stage and freezes the pipeline. It waits for the pipeline to drain, bounded by a timeout. It then reports the trap PC and exit code (a0) to the simulation or debug environment over a valid/ready handshake and holds the core halted until a resume request arrives. It sits between the core's trap pipeline and the top-level environment interface.

## Interface
Parameters:
- XLEN, 64, data/address width of captured PC and exit code
- DRAIN_TIMEOUT, 16, maximum DRAIN cycles before forced report (>=2)

Ports:
- clk  in  1  core clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- trap_in  in  1  one-cycle trap pulse (registered ebreak)
- trap_pc  in  XLEN  PC of trapping instruction, valid with trap_in
- trap_code  in  XLEN  a0 value at trap, valid with trap_in
- pipe_idle  in  1  pipeline has no in-flight instructions
- stall_req  out  1  freeze fetch/issue
- rpt_valid  out  1  report available
- rpt_ready  in  1  environment accepts report
- rpt_pc  out  XLEN  captured trap_pc
- rpt_code  out  XLEN  captured trap_code
- rpt_good  out  1  rpt_code == 0
- rpt_timeout  out  1  drain ended by timeout, not pipe_idle
- halted  out  1  core halted, report consumed
- resume  in  1  one-cycle request to leave HALTED

## Operation
- States: RUN, DRAIN, REPORT, HALTED.
- RUN: trap_in=1 -> capture trap_pc/trap_code, clear counter, go DRAIN. Otherwise stay.
- DRAIN: counter increments each cycle.
  - pipe_idle=1 -> REPORT with rpt_timeout=0.
  - Else counter==DRAIN_TIMEOUT-1 -> REPORT with rpt_timeout=1.
  - pipe_idle takes priority when both conditions hold in the same cycle.
- REPORT: rpt_valid=1. rpt_pc, rpt_code, rpt_good and rpt_timeout are held stable until rpt_valid&&rpt_ready, which moves the state to HALTED.
- HALTED: halted=1. resume=1 -> RUN; next-state logic clears rpt_timeout and the counter.
- stall_req=1 in DRAIN, REPORT and HALTED; 0 in RUN.
- trap_in is ignored outside RUN: no recapture, no state change. resume is ignored outside HALTED.
- trap_in and resume arriving together while HALTED: resume wins and the trap is dropped.
- rpt_good is combinational from the captured code: the reduction NOR of rpt_code.
- Counter width is $clog2(DRAIN_TIMEOUT). It never wraps; it saturates by leaving DRAIN.

## Timing
- Reset (async assert, sync release) sets state=RUN, stall_req=0, rpt_valid=0, rpt_pc=0, rpt_code=0, rpt_good=1 (code 0), rpt_timeout=0, halted=0, counter=0.
- Reset asserted mid-operation aborts everything and drops a pending report.
- trap_in high at edge N -> state DRAIN and stall_req=1 after edge N.
- pipe_idle sampled high at the first DRAIN edge (N+1) -> rpt_valid=1 after edge N+1. Minimum trap-to-report latency is 2 cycles.
- Timeout path: rpt_valid rises DRAIN_TIMEOUT+1 cycles after the trap edge.
- rpt_ready may already be high when rpt_valid rises; the handshake then completes that same cycle and halted=1 follows one cycle later.
- resume at edge M in HALTED -> stall_req=0 and halted=0 after edge M.
- All outputs are registered except rpt_good.

## Structure
- Package ysyx_22040125_halt_pkg holds:
  - state enum halt_state_e {RUN, DRAIN, REPORT, HALTED}
  - default DRAIN_TIMEOUT localparam
- Sub-module ysyx_22040125_halt_timer: clearable saturating up-counter with a terminal-count flag, used for the drain bound.
- Capture registers and FSM live in the top module.

## Test plan
- Good trap: trap_in with trap_pc=0x8000_0010, trap_code=0; pipe_idle=1; rpt_ready=1 -> rpt_valid 2 cycles after trap, rpt_good=1, rpt_timeout=0, halted next cycle.
- Bad trap with backpressure: trap_code=0x1; rpt_ready held low 5 cycles -> rpt_valid/rpt_pc/rpt_code stable for all 5, rpt_good=0, halted only after rpt_ready.
- Timeout: DRAIN_TIMEOUT=16, pipe_idle=0 throughout -> rpt_valid 17 cycles after trap, rpt_timeout=1.
- Ignored events: second trap_in during DRAIN with trap_pc=0xDEAD -> rpt_pc keeps the first PC. resume during REPORT -> no effect.
- Resume and retrap: resume in HALTED -> stall_req=0 next cycle. A new trap_code=0x2 then reports 0x2 with rpt_timeout cleared.
- Async reset mid-DRAIN and mid-REPORT: assert rst between edges -> all outputs at reset values immediately, state RUN after release.
